multicycle_processor: RTL
=========================

# multicycle_processor

Parametrised multi-cycle successor to the single-cycle 10-bit processor. It uses a fetch/decode/execute/memory/write-back state machine. Instruction and data memories sit outside the block, behind request/acknowledge handshakes, so they can take a variable number of wait states. An optional iterative multiplier can be compiled in. This is the top-level core that the FPGA wrapper instantiates.

## Interface
- DATA_W, default 10: register, data, address and instruction width; must be at least 10.
- NUM_REGS, default 8: register count, a power of two; RAW = clog2(NUM_REGS).
- RESET_PC, default 0: PC value after reset.
- CLK, input, 1: the single clock.
- RESET, input, 1: synchronous, active-high reset.
- IMEM_REQ, output, 1: instruction fetch request.
- IMEM_ADDR, output, DATA_W: fetch address; always equals the PC.
- IMEM_ACK, input, 1: fetch complete; IMEM_RDATA is valid in the same cycle.
- IMEM_RDATA, input, DATA_W: instruction word.
- DMEM_REQ, output, 1: data access request.
- DMEM_WE, output, 1: 1 for a store, 0 for a load.
- DMEM_ADDR, output, DATA_W: data address.
- DMEM_WDATA, output, DATA_W: store data.
- DMEM_ACK, input, 1: data access complete; DMEM_RDATA is valid for loads.
- DMEM_RDATA, input, DATA_W: load data.
- PC_OUT, output, DATA_W: current PC.
- RETIRE, output, 1: one-cycle pulse on each instruction's write-back cycle.
- HALT, output, 1: high while in the HALTED state.

## Operation
- Instruction fields:
  - opcode = [DATA_W-1 -: 4]
  - rd = [DATA_W-5 -: RAW]
  - rs = next RAW bits below rd
  - imm = remaining low bits, zero-extended
  - JMP target = all bits below the opcode, zero-extended
- Opcodes:
  - 0000 ADD: rd = rd + rs
  - 0001 SUB: rd = rd - rs
  - 0010 AND: rd = rd & rs
  - 0011 OR: rd = rd | rs
  - 0100 LDI: rd = imm
  - 0101 LD: rd = MEM[rs]
  - 0110 ST: MEM[rs] = rd
  - 0111 BEQZ: if rd == 0 then PC = rs
  - 1000 JMP
  - 1001 MUL (see Configuration)
  - 1111 HALT
  - all other opcodes are NOPs
- Arithmetic is modulo 2^DATA_W; carry and borrow are discarded.
- States and transitions:
  - FETCH: wait for IMEM_ACK, latch the instruction register, go to DECODE.
  - DECODE: read rd and rs into operand latches, go to EXEC.
  - EXEC: compute the ALU result or branch target. LD and ST go to MEM; HALT goes to HALTED; everything else goes to WB.
  - MEM: wait for DMEM_ACK, then go to WB.
  - WB: write rd (ALU, LDI, LD, MUL), update the PC (branch target, JMP target, or PC+1 with wrap), pulse RETIRE, go to FETCH.
  - HALTED: absorbing; only RESET leaves it. PC stays at the HALT instruction's address.
- Register file resets to all zeros.

## Timing
- Reset values: PC_OUT = RESET_PC, state = FETCH, all REQ outputs 0, DMEM_WE 0, RETIRE 0, HALT 0.
- REQ is registered. It rises on entry to FETCH or MEM and stays high, with address and data held stable, until the rising edge that samples ACK = 1. It is low in the following cycle.
- ACK is ignored whenever REQ is low.
- Zero-wait memory (ACK high in REQ's first cycle) gives these latencies:
  - ALU, LDI, branch, JMP, NOP: 4 cycles
  - LD, ST: 5 cycles
  - MUL: 3 + DATA_W cycles
- Each memory wait cycle adds one cycle.
- RESET during a pending REQ drops REQ the next cycle; a late ACK afterwards is ignored.
- A branch or JMP to the instruction's own address is legal and loops forever.
- PC+1 from all-ones wraps to 0.

## Configuration
- MUL_EN defined:
  - opcode 1001 computes rd = low DATA_W bits of rd*rs.
  - The multiplier is shift-add, one bit per cycle, and stays in EXEC for DATA_W cycles.
  - RESET mid-multiply aborts with no register write.
- MUL_EN undefined: 1001 executes as a NOP (4 cycles) and no multiplier logic is built.

## Structure
- proc_pkg: opcode localparams and the state enum (FETCH, DECODE, EXEC, MEM, WB, HALTED).
- Sub-module seq_multiplier (start/done handshake, DATA_W-parameterised) is instantiated only under MUL_EN.

## Test plan
- Zero-wait program LDI r1,5; LDI r2,3; ADD r1,r2; HALT -> r1 = 8, four RETIRE pulses, HALT high, PC_OUT = 3.
- IMEM_ACK delayed 3 cycles on every fetch -> IMEM_ADDR stays stable while REQ is high, and each instruction takes 3 extra cycles.
- ST r1 to address in r2 = 7, then LD into r3 with DMEM_ACK delayed 2 -> DMEM_WE = 1 for the store, and r3 equals the stored value.
- BEQZ taken (rd = 0, rs = 9) -> next IMEM_ADDR = 9; not taken -> PC+1. JMP from PC 1023 with DATA_W = 10 targets correctly; a NOP at 1023 wraps to 0.
- RESET asserted while IMEM_REQ is pending -> REQ is low next cycle, PC = RESET_PC, registers zero.
- With MUL_EN: 25 × 41 -> 1025 mod 1024 = 1, latency 13 cycles; without MUL_EN the same instruction changes no register.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: opcode encodings and FSM state type shared by the multicycle core.
package proc_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_LDI  = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_BEQZ = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_MUL  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hf;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALTED} state_t;
endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one bit per cycle, W cycles from start to the done cycle.
module seq_multiplier #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] product
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0] mc, mp;
  logic [CW-1:0] cnt;
  logic busy;
  // done is combinational so the caller leaves its wait state on the edge that takes the last step
  assign done = busy && cnt == CW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      mc <= '0;
      mp <= '0;
      product <= '0;
    end else if (start && !busy) begin
      product <= b[0] ? a : '0;
      mc <= a << 1;
      mp <= b >> 1;
      cnt <= CW'(W - 1);
      busy <= 1'b1;
    end else if (busy) begin
      product <= product + (mp[0] ? mc : '0);
      mc <= mc << 1;
      mp <= mp >> 1;
      cnt <= cnt - 1'b1;
      busy <= cnt != CW'(1);
    end
  end
endmodule

// File: rtl/multicycle_processor.sv
// multicycle_processor: FSM core with handshaked instruction/data memories; define MUL_EN to build the multiplier.
module multicycle_processor
  import proc_pkg::*;
#(
  parameter int                DATA_W   = 10,
  parameter int                NUM_REGS = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              IMEM_REQ,
  output logic [DATA_W-1:0] IMEM_ADDR,
  input  logic              IMEM_ACK,
  input  logic [DATA_W-1:0] IMEM_RDATA,
  output logic              DMEM_REQ,
  output logic              DMEM_WE,
  output logic [DATA_W-1:0] DMEM_ADDR,
  output logic [DATA_W-1:0] DMEM_WDATA,
  input  logic              DMEM_ACK,
  input  logic [DATA_W-1:0] DMEM_RDATA,
  output logic [DATA_W-1:0] PC_OUT,
  output logic              RETIRE,
  output logic              HALT
);
  localparam int RAW = $clog2(NUM_REGS);
  localparam int IMW = DATA_W - 4 - RAW;
  state_t state;
  logic [DATA_W-1:0] pc, ir, op_d, op_s, result, alu, mul_p;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [3:0] opc;
  logic [RAW-1:0] rd, rs;
  logic mul_done, wen;
  assign opc = ir[DATA_W-1 -: 4];
  assign rd = ir[DATA_W-5 -: RAW];
  assign rs = ir[DATA_W-5-RAW -: RAW];
  assign IMEM_ADDR = pc;
  assign PC_OUT = pc;
  assign HALT = state == HALTED;
`ifdef MUL_EN
  localparam bit HAS_MUL = 1'b1;
  seq_multiplier #(.W(DATA_W)) u_mul (
    .clk(CLK), .rst(RESET), .start(state == EXEC && opc == OP_MUL),
    .a(op_d), .b(op_s), .done(mul_done), .product(mul_p)
  );
`else
  localparam bit HAS_MUL = 1'b0;
  assign mul_done = 1'b1;
  assign mul_p = '0;
`endif
  assign wen = opc < OP_ST || (HAS_MUL && opc == OP_MUL);
  // LDI has no rs operand, so its immediate is every bit below rd
  always_comb
    alu = opc == OP_ADD ? op_d + op_s :
          opc == OP_SUB ? op_d - op_s :
          opc == OP_AND ? op_d & op_s :
          opc == OP_OR  ? op_d | op_s : DATA_W'(ir[IMW-1:0]);
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      op_d <= '0;
      op_s <= '0;
      result <= '0;
      IMEM_REQ <= 1'b0;
      DMEM_REQ <= 1'b0;
      DMEM_WE <= 1'b0;
      DMEM_ADDR <= '0;
      DMEM_WDATA <= '0;
      RETIRE <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      RETIRE <= 1'b0;
      case (state)
        FETCH:
          if (IMEM_REQ && IMEM_ACK) begin
            ir <= IMEM_RDATA;
            IMEM_REQ <= 1'b0;
            state <= DECODE;
          end else IMEM_REQ <= 1'b1;
        DECODE: begin
          op_d <= regs[rd];
          op_s <= regs[rs];
          state <= EXEC;
        end
        EXEC: begin
          result <= alu;
          if (opc == OP_LD || opc == OP_ST) begin
            DMEM_REQ <= 1'b1;
            DMEM_WE <= opc == OP_ST;
            DMEM_ADDR <= op_s;
            DMEM_WDATA <= op_d;
            state <= MEM;
          end else if (opc == OP_HALT) begin
            RETIRE <= 1'b1;
            state <= HALTED;
          end else if (opc != OP_MUL || mul_done) begin
            RETIRE <= 1'b1;
            state <= WB;
          end
        end
        MEM:
          if (DMEM_ACK) begin
            result <= DMEM_RDATA;
            DMEM_REQ <= 1'b0;
            DMEM_WE <= 1'b0;
            RETIRE <= 1'b1;
            state <= WB;
          end
        WB: begin
          if (wen) regs[rd] <= opc == OP_MUL ? mul_p : result;
          pc <= opc == OP_BEQZ && op_d == '0 ? op_s :
                opc == OP_JMP ? DATA_W'(ir[DATA_W-5:0]) : pc + 1'b1;
          IMEM_REQ <= 1'b1;
          state <= FETCH;
        end
        default: ;
      endcase
    end
  end
endmodule
